// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates at the tail, captures two CDBs,
// retires one ready entry per cycle from the head, and flushes on mispredict.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned TAG_W    = $clog2(ROB_SIZE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq_valid,
  input  logic [REG_W-1:0]  enq_rd,
  input  logic              enq_regwrite,
  input  logic              enq_is_store,
  input  logic              enq_ready,
  input  logic [DATA_W-1:0] enq_value,
  output logic              enq_accept,
  output logic [TAG_W-1:0]  rob_tail,
  output logic [TAG_W-1:0]  rob_count,
  output logic              rob_full,
  input  logic [TAG_W-1:0]  cdb1_tag,
  input  logic [DATA_W-1:0] cdb1_value,
  input  logic [TAG_W-1:0]  cdb2_tag,
  input  logic [DATA_W-1:0] cdb2_value,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              lookup_ready,
  output logic [DATA_W-1:0] lookup_value,
  input  logic              flush,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_value,
  output logic              commit_wb,
  output logic              commit_store
);

  localparam logic [TAG_W-1:0] SizeTag = TAG_W'(ROB_SIZE);
  localparam logic [TAG_W-1:0] FirstTag = TAG_W'(1);

  // Slot i holds tag i+1; tag 0 is reserved for "value in register file".
  function automatic logic [TAG_W-1:0] slot_tag(input int idx);
    return TAG_W'(idx + 1);
  endfunction

  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] tag);
    return (tag == SizeTag) ? FirstTag : tag + 1'b1;
  endfunction

  logic [ROB_SIZE-1:0] busy_q, busy_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;
  logic [ROB_SIZE-1:0] regwrite_q, regwrite_d;
  logic [ROB_SIZE-1:0] store_q, store_d;
  logic [REG_W-1:0]    rd_q [ROB_SIZE];
  logic [REG_W-1:0]    rd_d [ROB_SIZE];
  logic [DATA_W-1:0]   value_q [ROB_SIZE];
  logic [DATA_W-1:0]   value_d [ROB_SIZE];

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W-1:0] count_q, count_d;

  logic              commit_valid_q;
  logic [TAG_W-1:0]  commit_tag_q;
  logic [REG_W-1:0]  commit_rd_q;
  logic [DATA_W-1:0] commit_value_q;
  logic              commit_wb_q;
  logic              commit_store_q;

  logic              head_ok;
  logic [REG_W-1:0]  head_rd;
  logic [DATA_W-1:0] head_value;
  logic              head_regwrite;
  logic              head_store;
  logic              commit_fire;

  assign rob_full    = (count_q == SizeTag);
  assign rob_tail    = tail_q;
  assign rob_count   = count_q;
  assign enq_accept  = enq_valid & ~rob_full & ~flush;
  assign commit_fire = head_ok & ~flush;

  always_comb begin
    head_ok       = 1'b0;
    head_rd       = '0;
    head_value    = '0;
    head_regwrite = 1'b0;
    head_store    = 1'b0;
    for (int i = 0; i < int'(ROB_SIZE); i++) begin
      if (head_q == slot_tag(i)) begin
        head_ok       = busy_q[i] & ready_q[i];
        head_rd       = rd_q[i];
        head_value    = value_q[i];
        head_regwrite = regwrite_q[i];
        head_store    = store_q[i];
      end
    end
  end

  // Lookup reads stored state only; same-cycle CDB traffic is not forwarded.
  always_comb begin
    lookup_ready = 1'b0;
    lookup_value = '0;
    for (int i = 0; i < int'(ROB_SIZE); i++) begin
      if (lookup_tag == slot_tag(i)) begin
        lookup_ready = busy_q[i] & ready_q[i];
        lookup_value = value_q[i];
      end
    end
  end

  always_comb begin
    busy_d     = busy_q;
    ready_d    = ready_q;
    regwrite_d = regwrite_q;
    store_d    = store_q;
    rd_d       = rd_q;
    value_d    = value_q;
    for (int i = 0; i < int'(ROB_SIZE); i++) begin
      // cdb2 first so cdb1 overrides it when both carry the same tag.
      if (cdb2_tag == slot_tag(i) && busy_q[i] && !ready_q[i]) begin
        value_d[i] = cdb2_value;
        ready_d[i] = 1'b1;
      end
      if (cdb1_tag == slot_tag(i) && busy_q[i] && !ready_q[i]) begin
        value_d[i] = cdb1_value;
        ready_d[i] = 1'b1;
      end
      if (commit_fire && head_q == slot_tag(i)) begin
        busy_d[i]  = 1'b0;
        ready_d[i] = 1'b0;
      end
      if (enq_accept && tail_q == slot_tag(i)) begin
        busy_d[i]     = 1'b1;
        ready_d[i]    = enq_ready;
        rd_d[i]       = enq_rd;
        regwrite_d[i] = enq_regwrite;
        store_d[i]    = enq_is_store;
        value_d[i]    = enq_value;
      end
    end
    if (flush) begin
      busy_d  = '0;
      ready_d = '0;
    end
  end

  always_comb begin
    head_d  = commit_fire ? next_tag(head_q) : head_q;
    tail_d  = enq_accept ? next_tag(tail_q) : tail_q;
    count_d = count_q;
    unique case ({enq_accept, commit_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      head_d  = FirstTag;
      tail_d  = FirstTag;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q         <= '0;
      ready_q        <= '0;
      head_q         <= FirstTag;
      tail_q         <= FirstTag;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_wb_q    <= 1'b0;
      commit_store_q <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_fire;
      if (commit_fire) begin
        commit_tag_q   <= head_q;
        commit_rd_q    <= head_rd;
        commit_value_q <= head_value;
        commit_wb_q    <= head_regwrite & (head_rd != '0);
        commit_store_q <= head_store;
      end
    end
  end

  // Payload is qualified by busy, so it needs no reset.
  always_ff @(posedge clk) begin
    regwrite_q <= regwrite_d;
    store_q    <= store_d;
    rd_q       <= rd_d;
    value_q    <= value_d;
  end

  assign commit_valid = commit_valid_q;
  assign commit_tag   = commit_tag_q;
  assign commit_rd    = commit_rd_q;
  assign commit_value = commit_value_q;
  assign commit_wb    = commit_wb_q;
  assign commit_store = commit_store_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, corner sequences, and random
// traffic checked against a queue-based model of in-flight entries.
module tb_reorder_buffer;

  localparam int N  = 16;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          enq_valid, enq_regwrite, enq_is_store, enq_ready;
  logic [RW-1:0] enq_rd;
  logic [DW-1:0] enq_value;
  logic          enq_accept;
  logic [TW-1:0] rob_tail, rob_count;
  logic          rob_full;
  logic [TW-1:0] cdb1_tag, cdb2_tag, lookup_tag;
  logic [DW-1:0] cdb1_value, cdb2_value;
  logic          lookup_ready;
  logic [DW-1:0] lookup_value;
  logic          flush;
  logic          commit_valid, commit_wb, commit_store;
  logic [TW-1:0] commit_tag;
  logic [RW-1:0] commit_rd;
  logic [DW-1:0] commit_value;

  int n_checks = 0;
  int n_fail   = 0;

  reorder_buffer #(.ROB_SIZE(N), .DATA_W(DW), .REG_W(RW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_rd(enq_rd), .enq_regwrite(enq_regwrite),
    .enq_is_store(enq_is_store), .enq_ready(enq_ready), .enq_value(enq_value),
    .enq_accept(enq_accept), .rob_tail(rob_tail), .rob_count(rob_count), .rob_full(rob_full),
    .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value), .cdb2_tag(cdb2_tag), .cdb2_value(cdb2_value),
    .lookup_tag(lookup_tag), .lookup_ready(lookup_ready), .lookup_value(lookup_value),
    .flush(flush), .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_rd(commit_rd), .commit_value(commit_value), .commit_wb(commit_wb),
    .commit_store(commit_store)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic ev; logic [4:0] rd; logic rw; logic rdy; logic [31:0] val;
    logic [4:0] c1t; logic [31:0] c1v; logic [4:0] c2t; logic [31:0] c2v; logic [4:0] lt;
    logic acc; logic [4:0] tail; logic [4:0] cnt; logic cv; logic [4:0] ctag;
    logic [4:0] crd; logic [31:0] cval; logic cwb; logic lr; logic [31:0] lv;
  } row_t;
  row_t tbl [15];

  typedef struct {
    int tag; bit rdy; logic [4:0] rd; bit rw; bit st; logic [31:0] val;
  } ment_t;
  ment_t mq[$];
  int mtail;
  bit ecv, ewb, est, eknown;
  logic [4:0] ectag, ecrd;
  logic [31:0] ecval;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    enq_valid = 0; enq_rd = 0; enq_regwrite = 0; enq_is_store = 0; enq_ready = 0;
    enq_value = 0; cdb1_tag = 0; cdb1_value = 0; cdb2_tag = 0; cdb2_value = 0;
    lookup_tag = 0; flush = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    set_idle();
  endtask

  task automatic do_reset();
    cyc();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic enq(input logic [4:0] rd, input logic rdy, input logic [31:0] val);
    enq_valid = 1; enq_rd = rd; enq_regwrite = 1; enq_ready = rdy; enq_value = val;
  endtask

  task automatic model_reset();
    mq.delete(); mtail = 1; ecv = 0; ectag = 0; ecrd = 0; ecval = 0; ewb = 0; est = 0;
    eknown = 1;
  endtask

  task automatic model_update();
    bit acc, fire;
    int k1, k2;
    ment_t e;
    if (reset) begin
      model_reset();
      return;
    end
    if (flush) begin
      mq.delete(); mtail = 1; ecv = 0;
      return;
    end
    acc  = enq_valid && mq.size() < N;
    fire = mq.size() > 0 && mq[0].rdy;
    k1 = -1; k2 = -1;
    foreach (mq[k]) begin
      if (cdb1_tag != 0 && mq[k].tag == int'(cdb1_tag) && !mq[k].rdy) k1 = k;
      if (cdb2_tag != 0 && mq[k].tag == int'(cdb2_tag) && !mq[k].rdy) k2 = k;
    end
    if (k2 >= 0) begin mq[k2].rdy = 1; mq[k2].val = cdb2_value; end
    if (k1 >= 0) begin mq[k1].rdy = 1; mq[k1].val = cdb1_value; end
    ecv = fire;
    if (fire) begin
      e = mq.pop_front();
      ectag = 5'(e.tag); ecrd = e.rd; ecval = e.val; ewb = e.rw && e.rd != 0; est = e.st;
      eknown = 0;
    end
    if (acc) begin
      e = '{mtail, enq_ready, enq_rd, enq_regwrite, enq_is_store, enq_value};
      mq.push_back(e);
      mtail = (mtail == N) ? 1 : mtail + 1;
    end
  endtask

  task automatic model_check();
    bit elr;
    logic [31:0] elv;
    chk("rnd_accept", enq_accept, enq_valid && !flush && mq.size() < N);
    chk("rnd_tail", rob_tail, mtail);
    chk("rnd_count", rob_count, mq.size());
    chk("rnd_full", rob_full, mq.size() == N);
    chk("rnd_cvalid", commit_valid, ecv);
    if (ecv || eknown) begin
      chk("rnd_ctag", commit_tag, ectag);
      chk("rnd_crd", commit_rd, ecrd);
      chk("rnd_cval", commit_value, ecval);
      chk("rnd_cwb", commit_wb, ewb);
      chk("rnd_cstore", commit_store, est);
    end
    elr = 0; elv = 0;
    foreach (mq[k]) if (mq[k].tag == int'(lookup_tag)) begin elr = mq[k].rdy; elv = mq[k].val; end
    chk("rnd_lready", lookup_ready, elr);
    if (elr || lookup_tag == 0) chk("rnd_lvalue", lookup_value, elv);
  endtask

  initial begin
    // ev rd rw rdy val | c1t c1v c2t c2v | lt | acc tail cnt cv ctag crd cval cwb | lr lv
    tbl[0]  = '{1, 1, 1, 0, 0,     0, 0,    0, 0,    0, 1, 1, 0, 0, 0, 0, 0,     0, 0, 0};
    tbl[1]  = '{1, 2, 1, 0, 0,     0, 0,    0, 0,    0, 1, 2, 1, 0, 0, 0, 0,     0, 0, 0};
    tbl[2]  = '{1, 3, 1, 0, 0,     0, 0,    0, 0,    0, 1, 3, 2, 0, 0, 0, 0,     0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0,     2, 'hAA, 0, 0,    2, 0, 4, 3, 0, 0, 0, 0,     0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0,     0, 0,    1, 'h55, 2, 0, 4, 3, 0, 0, 0, 0,     0, 1, 'hAA};
    tbl[5]  = '{0, 0, 0, 0, 0,     0, 0,    0, 0,    1, 0, 4, 3, 0, 0, 0, 0,     0, 1, 'h55};
    tbl[6]  = '{0, 0, 0, 0, 0,     0, 0,    0, 0,    0, 0, 4, 2, 1, 1, 1, 'h55,  1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0,     0, 0,    0, 0,    0, 0, 4, 1, 1, 2, 2, 'hAA,  1, 0, 0};
    tbl[8]  = '{1, 0, 1, 1, 'h100, 3, 'h33, 0, 0,    0, 1, 4, 1, 0, 0, 0, 0,     0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0,     0, 0,    0, 0,    4, 0, 5, 2, 0, 0, 0, 0,     0, 1, 'h100};
    tbl[10] = '{0, 0, 0, 0, 0,     0, 0,    0, 0,    0, 0, 5, 1, 1, 3, 3, 'h33,  1, 0, 0};
    tbl[11] = '{1, 7, 1, 1, 'h77,  0, 0,    0, 0,    0, 1, 5, 0, 1, 4, 0, 'h100, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0,     0, 0,    0, 0,    5, 0, 6, 1, 0, 0, 0, 0,     0, 1, 'h77};
    tbl[13] = '{0, 0, 0, 0, 0,     0, 0,    0, 0,    0, 0, 6, 0, 1, 5, 7, 'h77,  1, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0,     0, 0,    0, 0,    0, 0, 6, 0, 0, 0, 0, 0,     0, 0, 0};

    set_idle();
    reset = 1;
    cyc();
    cyc();
    #1;
    chk("rst_tail", rob_tail, 1);
    chk("rst_count", rob_count, 0);
    chk("rst_full", rob_full, 0);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_ctag", commit_tag, 0);
    chk("rst_crd", commit_rd, 0);
    chk("rst_cval", commit_value, 0);
    chk("rst_cwb", commit_wb, 0);
    chk("rst_cstore", commit_store, 0);
    reset = 0;

    for (int r = 0; r < 15; r++) begin
      cyc();
      enq_valid = tbl[r].ev; enq_rd = tbl[r].rd; enq_regwrite = tbl[r].rw;
      enq_ready = tbl[r].rdy; enq_value = tbl[r].val;
      cdb1_tag = tbl[r].c1t; cdb1_value = tbl[r].c1v;
      cdb2_tag = tbl[r].c2t; cdb2_value = tbl[r].c2v; lookup_tag = tbl[r].lt;
      #1;
      chk($sformatf("tbl%0d_accept", r), enq_accept, tbl[r].acc);
      chk($sformatf("tbl%0d_tail", r), rob_tail, tbl[r].tail);
      chk($sformatf("tbl%0d_count", r), rob_count, tbl[r].cnt);
      chk($sformatf("tbl%0d_cvalid", r), commit_valid, tbl[r].cv);
      chk($sformatf("tbl%0d_lready", r), lookup_ready, tbl[r].lr);
      if (tbl[r].lr || tbl[r].lt == 0) chk($sformatf("tbl%0d_lvalue", r), lookup_value, tbl[r].lv);
      if (tbl[r].cv) begin
        chk($sformatf("tbl%0d_ctag", r), commit_tag, tbl[r].ctag);
        chk($sformatf("tbl%0d_crd", r), commit_rd, tbl[r].crd);
        chk($sformatf("tbl%0d_cval", r), commit_value, tbl[r].cval);
        chk($sformatf("tbl%0d_cwb", r), commit_wb, tbl[r].cwb);
      end
    end

    // Fill, reject while full (even alongside a commit), then wrap to tag 1.
    do_reset();
    for (int i = 0; i < N; i++) begin
      cyc();
      enq(5'(i), 0, 0);
    end
    cyc();
    enq(9, 0, 0);
    #1;
    chk("full_flag", rob_full, 1);
    chk("full_count", rob_count, N);
    chk("full_reject", enq_accept, 0);
    cyc();
    cdb1_tag = 1; cdb1_value = 32'h1;
    #1;
    chk("full_tail_hold", rob_tail, 1);
    chk("full_still", rob_full, 1);
    cyc();
    enq(9, 0, 0);
    #1;
    chk("full_reject_commit", enq_accept, 0);
    cyc();
    enq(4, 1, 32'hBEEF);
    #1;
    chk("drop_full", rob_full, 0);
    chk("drop_count", rob_count, N - 1);
    chk("drop_tail", rob_tail, 1);
    chk("drop_cvalid", commit_valid, 1);
    chk("drop_ctag", commit_tag, 1);
    chk("drop_cval", commit_value, 1);
    chk("wrap_accept", enq_accept, 1);
    cyc();
    lookup_tag = 1;
    #1;
    chk("wrap_tail", rob_tail, 2);
    chk("wrap_count", rob_count, N);
    chk("wrap_lready", lookup_ready, 1);
    chk("wrap_lvalue", lookup_value, 32'hBEEF);

    // Dual-CDB priority, idle tag, stale and non-busy tags.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc();
      enq(5'(i + 1), 0, 0);
    end
    cyc();
    cdb1_tag = 5; cdb1_value = 32'h11; cdb2_tag = 5; cdb2_value = 32'h22;
    cyc();
    lookup_tag = 5;
    cdb1_tag = 0; cdb1_value = 32'hFF; cdb2_tag = 5; cdb2_value = 32'h99;
    #1;
    chk("dual_lready", lookup_ready, 1);
    chk("dual_lvalue", lookup_value, 32'h11);
    cyc();
    lookup_tag = 5; cdb1_tag = 9; cdb1_value = 32'h77;
    #1;
    chk("stale_lvalue", lookup_value, 32'h11);
    cyc();
    lookup_tag = 9;
    #1;
    chk("nonbusy_lready", lookup_ready, 0);
    chk("cdb_count", rob_count, 5);
    cyc();
    lookup_tag = 4;
    #1;
    chk("idle_cdb_lready", lookup_ready, 0);

    // Flush beats same-cycle enqueue, CDB hit and a ready head.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      enq(5'(i + 1), 0, 0);
    end
    cyc();
    enq(4, 0, 0);
    cdb1_tag = 1; cdb1_value = 32'h5A;
    cyc();
    flush = 1;
    enq(6, 1, 32'h66);
    cdb2_tag = 2; cdb2_value = 32'h3C;
    #1;
    chk("flush_accept", enq_accept, 0);
    chk("preflush_count", rob_count, 4);
    cyc();
    #1;
    chk("flush_count", rob_count, 0);
    chk("flush_tail", rob_tail, 1);
    chk("flush_cvalid", commit_valid, 0);
    chk("flush_full", rob_full, 0);
    for (int t = 0; t <= N; t++) begin
      lookup_tag = 5'(t);
      #1;
      chk($sformatf("flush_lready%0d", t), lookup_ready, 0);
    end
    cyc();
    enq(2, 0, 0);
    #1;
    chk("postflush_cvalid", commit_valid, 0);
    cyc();
    #1;
    chk("postflush_tail", rob_tail, 2);

    // Random traffic against the queue model.
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      int enq_pct;
      cyc();
      enq_pct = ((n / 400) % 2 == 0) ? 85 : 30;
      enq_valid    = ($urandom_range(0, 99) < enq_pct);
      enq_rd       = 5'($urandom_range(0, 31));
      enq_regwrite = 1'($urandom_range(0, 1));
      enq_is_store = 1'($urandom_range(0, 1));
      enq_ready    = ($urandom_range(0, 99) < 20);
      enq_value    = $urandom;
      cdb1_value   = $urandom;
      cdb2_value   = $urandom;
      if (mq.size() > 0 && $urandom_range(0, 99) < 60)
        cdb1_tag = 5'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else
        cdb1_tag = 5'($urandom_range(0, N));
      if (mq.size() > 0 && $urandom_range(0, 99) < 50)
        cdb2_tag = 5'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else
        cdb2_tag = 5'($urandom_range(0, N));
      lookup_tag = 5'($urandom_range(0, N));
      flush      = ($urandom_range(0, 999) < 15);
      reset      = ($urandom_range(0, 999) < 4);
      #1;
      model_check();
      @(posedge clk);
      model_update();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
